// File: rtl/pattern_tx.sv
// pattern_tx: serialises a captured pattern MSB first, load_rep+1 contiguous passes, then a one-cycle done.
// Define PATTERN_TX_LOOP_EN to add the loop_en input, which keeps the stream repeating until abort or reset.
module pattern_tx #(
    parameter int WIDTH = 8,
    parameter int REP_W = 4
) (
    input  logic             clk,
    input  logic             rst,
`ifdef PATTERN_TX_LOOP_EN
    input  logic             loop_en,
`endif
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    input  logic [REP_W-1:0] load_rep,
    input  logic             abort,
    output logic             dout,
    output logic             dout_valid,
    output logic             busy,
    output logic             done
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;
    logic [1:0]       state;
    logic [WIDTH-1:0] shadow_data;
    logic [WIDTH-1:0] sreg;
    logic [REP_W-1:0] shadow_rep;
    logic [REP_W-1:0] pass_cnt;
    logic [CW-1:0]    bit_cnt;
    logic             last_bit;
    logic             more;
    assign load_ready = rst && state == IDLE;
    assign last_bit   = bit_cnt == CW'(WIDTH - 1);
    // passes completed so far against the captured repeat count; counts up so it can never underflow
    assign more       = pass_cnt != shadow_rep;
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            shadow_data <= '0;
            shadow_rep  <= '0;
            sreg        <= '0;
            pass_cnt    <= '0;
            bit_cnt     <= '0;
            dout        <= 1'b0;
            dout_valid  <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else if (state == IDLE) begin
            if (load_valid) begin
                shadow_data <= load_data;
                shadow_rep  <= load_rep;
                sreg        <= load_data << 1;
                dout        <= load_data[WIDTH-1];
                dout_valid  <= 1'b1;
                busy        <= 1'b1;
                bit_cnt     <= '0;
                pass_cnt    <= '0;
                state       <= SHIFT;
            end
        end else if (state == SHIFT) begin
            if (abort) begin
                state      <= IDLE;
                dout       <= 1'b0;
                dout_valid <= 1'b0;
                busy       <= 1'b0;
                bit_cnt    <= '0;
            end else if (!last_bit) begin
                dout    <= sreg[WIDTH-1];
                sreg    <= sreg << 1;
                bit_cnt <= bit_cnt + CW'(1);
            end else if (more) begin
                dout     <= shadow_data[WIDTH-1];
                sreg     <= shadow_data << 1;
                bit_cnt  <= '0;
                pass_cnt <= pass_cnt + REP_W'(1);
`ifdef PATTERN_TX_LOOP_EN
            end else if (loop_en) begin
                dout     <= shadow_data[WIDTH-1];
                sreg     <= shadow_data << 1;
                bit_cnt  <= '0;
                pass_cnt <= '0;
`endif
            end else begin
                state      <= DONE;
                dout       <= 1'b0;
                dout_valid <= 1'b0;
                done       <= 1'b1;
                bit_cnt    <= '0;
            end
        end else begin
            state <= IDLE;
            done  <= 1'b0;
            busy  <= 1'b0;
        end
    end
endmodule

// File: tb/tb_pattern_tx.sv
// tb_pattern_tx: directed vectors for pattern_tx with hand-computed serial streams.
module tb_pattern_tx;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       loop_en = 1'b0;
    logic       load_valid = 1'b0;
    logic       load_ready;
    logic [7:0] load_data = '0;
    logic [3:0] load_rep = '0;
    logic       abort = 1'b0;
    logic       dout;
    logic       dout_valid;
    logic       busy;
    logic       done;
    int         n_chk = 0;
    int         n_pass = 0;
    logic [63:0] bits;
    int         nvalid;
    int         ndone;

    always #5 clk = ~clk;

    pattern_tx #(.WIDTH(8), .REP_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
`ifdef PATTERN_TX_LOOP_EN
        .loop_en    (loop_en),
`endif
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .load_rep   (load_rep),
        .abort      (abort),
        .dout       (dout),
        .dout_valid (dout_valid),
        .busy       (busy),
        .done       (done)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got %0h exp %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic [3:0] r);
        check("ready_before_load", load_ready, 1);
        load_data  = d;
        load_rep   = r;
        load_valid = 1'b1;
        tick();
        load_valid = 1'b0;
    endtask

    task automatic collect(input int n);
        bits = '0;
        nvalid = 0;
        ndone = 0;
        for (int i = 0; i < n; i++) begin
            bits = {bits[62:0], dout};
            nvalid += int'(dout_valid);
            ndone += int'(done);
            tick();
        end
    endtask

    initial begin
        tick();
        tick();
        check("rst_outs", {dout, dout_valid, busy, done}, 4'b0000);
        check("rst_ready_low", load_ready, 0);
        rst = 1'b1;
        #1;
        check("ready_after_rst", load_ready, 1);

        send(8'b10110101, 4'd0);
        collect(8);
        check("single_bits", bits, 64'hB5);
        check("single_valid", nvalid, 8);
        check("single_no_early_done", ndone, 0);
        check("single_done_cycle", {done, dout_valid, dout, busy}, 4'b1001);
        tick();
        check("single_idle", {load_ready, done, busy}, 3'b100);

        send(8'b10101010, 4'd2);
        collect(24);
        check("rep_bits", bits, 64'hAAAAAA);
        check("rep_valid", nvalid, 24);
        check("rep_no_early_done", ndone, 0);
        check("rep_done", done, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("rep_idle_abort_ignored", {load_ready, done, busy}, 3'b100);

        send(8'b10110101, 4'd0);
        tick();
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_stop", {dout_valid, dout, busy, done}, 4'b0000);
        check("abort_ready", load_ready, 1);
        collect(10);
        check("abort_no_done", ndone, 0);
        check("abort_no_valid", nvalid, 0);

        send(8'b10110101, 4'd0);
        repeat (7) tick();
        check("abort_last_bit_valid", dout_valid, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_last_wins", {done, dout_valid, busy, load_ready}, 4'b0001);

        send(8'h5A, 4'd1);
        repeat (4) tick();
        rst = 1'b0;
        tick();
        check("midrst_outs", {dout, dout_valid, busy, done, load_ready}, 5'b00000);
        rst = 1'b1;
        #1;
        send(8'hC3, 4'd0);
        collect(8);
        check("postrst_bits", bits, 64'hC3);
        check("postrst_valid", nvalid, 8);
        tick();

        send(8'h96, 4'd0);
        load_data  = 8'h0F;
        load_rep   = 4'd3;
        load_valid = 1'b1;
        collect(8);
        check("busy_hold_bits", bits, 64'h96);
        check("busy_hold_done", done, 1);
        tick();
        check("busy_hold_ready", load_ready, 1);
        tick();
        load_valid = 1'b0;
        collect(32);
        check("second_bits", bits, 64'h0F0F0F0F);
        check("second_valid", nvalid, 32);
        check("second_no_early_done", ndone, 0);
        check("second_done", done, 1);
        tick();

`ifdef PATTERN_TX_LOOP_EN
        loop_en = 1'b1;
        send(8'hB5, 4'd0);
        collect(40);
        check("loop_bits", bits, 64'hB5B5B5B5B5);
        check("loop_valid", nvalid, 40);
        check("loop_no_done", ndone, 0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        loop_en = 1'b0;
        check("loop_abort", {dout_valid, busy, done, load_ready}, 4'b0001);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/pattern_tx.md
PATTERN_TX -- requirements
Module: pattern_tx

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8: pattern length in bits, legal range 2..32.
REQ-002 The module SHALL have parameter REP_W, default 4: width of the repeat-count field.
REQ-003 Port clk  in  1: single clock; all logic SHALL sample on the rising edge.
REQ-004 Port rst  in  1: reset, synchronous and active-low; rst==0 at a rising clk edge resets the block.
REQ-005 Port load_valid  in  1: a pattern is offered on load_data/load_rep.
REQ-006 Port load_ready  out  1: the block can accept a pattern; it SHALL be 1 only in IDLE with rst==1.
REQ-007 Port load_data  in  WIDTH: the pattern, transmitted MSB first.
REQ-008 Port load_rep  in  REP_W: repeat count; the pattern SHALL be sent load_rep+1 times.
REQ-009 Port abort  in  1: terminates an active transmission.
REQ-010 Port dout  out  1: serial bit, intended to drive a sequence detector's din.
REQ-011 Port dout_valid  out  1: dout carries a pattern bit this cycle.
REQ-012 Port busy  out  1: 1 in SHIFT and DONE.
REQ-013 Port done  out  1: one-cycle pulse marking normal completion.

Function
REQ-014 The FSM SHALL have three states, IDLE, SHIFT and DONE, and all outputs SHALL be registered except load_ready.
REQ-015 The handshake SHALL complete at an edge where load_valid==1 and load_ready==1 (edge E0); load_data and load_rep SHALL be captured into shadow registers and the FSM SHALL enter SHIFT.
REQ-016 In SHIFT, bit WIDTH-1-k of the pattern SHALL appear on dout with dout_valid==1 during cycle k+1 after E0, for k = 0..WIDTH-1, giving a latency of exactly one cycle from acceptance to the first bit.
REQ-017 After the last bit of a pass, if the repeats remaining are greater than 0, the block SHALL reload from the shadow register with no gap cycle (a contiguous stream) and decrement the remaining count.
REQ-018 After the last bit of the final pass, the FSM SHALL spend one cycle in DONE with done==1, dout_valid==0 and dout==0, then return to IDLE.
REQ-019 Outside SHIFT, dout_valid and dout SHALL be 0.
REQ-020 If abort==1 at an edge while in SHIFT, the next state SHALL be IDLE with dout_valid==0 and no done pulse; in IDLE or DONE, abort SHALL be ignored.
REQ-021 If abort coincides with the final bit, abort SHALL win and no done pulse SHALL occur.
REQ-022 load_valid SHALL be ignored while busy==1, leaving the shadow registers unchanged.
REQ-023 The bit counter SHALL wrap from WIDTH-1 to 0, and the repeat counter SHALL never underflow.

Reset
REQ-024 On reset the state SHALL be IDLE and dout, dout_valid, busy and done SHALL be 0; the shadow and counter registers SHALL be 0.
REQ-025 Reset SHALL take priority over abort and the handshake, including in mid-transmission, and the output stream SHALL stop on the cycle after the reset edge.
REQ-026 load_ready SHALL be 0 while rst==0 and SHALL be 1 in the first cycle after rst returns to 1.

Configuration
REQ-027 When macro PATTERN_TX_LOOP_EN is defined, an input port loop_en (1 bit) SHALL exist.
REQ-028 With PATTERN_TX_LOOP_EN defined, if loop_en==1 at the last bit of the final pass, the repeat count SHALL reload to the captured load_rep and the stream SHALL continue with no gap and no done pulse; only abort or reset SHALL end it.
REQ-029 Without PATTERN_TX_LOOP_EN, the loop_en port and the loop logic SHALL be absent, and behaviour SHALL be identical to loop_en==0.

Verification
REQ-030 WIDTH=8, load_data=8'b10110101, load_rep=0 -> dout 1,0,1,1,0,1,0,1 in cycles 1-8 after E0 with dout_valid==1; done==1 in cycle 9; load_ready==1 in cycle 10.
REQ-031 load_data=8'b10101010, load_rep=2 -> 24 contiguous valid bits (1010... repeated) followed by a single done pulse.
REQ-032 abort asserted during the 3rd bit -> dout_valid==0 from the 4th cycle, no done pulse, load_ready==1.
REQ-033 rst=0 during the 5th bit -> all outputs 0 next cycle; a new load after rst=1 transmits correctly from its first bit.
REQ-034 load_valid held with a different pattern while busy -> the original pattern is transmitted unchanged, and the new pattern is accepted in IDLE.
REQ-035 PATTERN_TX_LOOP_EN defined, loop_en=1, load_rep=0 -> the pattern repeats for 5 or more passes with no done pulse, and abort then stops it.
